// File: rtl/y86_pkg.sv
// Shared Y86 memory-stage definitions: icode constants, memory op and FSM state enums.
package y86_pkg;

    localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
    localparam logic [3:0] ICODE_CALL   = 4'd8;
    localparam logic [3:0] ICODE_RET    = 4'd9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
    localparam logic [3:0] ICODE_POPQ   = 4'd11;

    typedef enum logic [2:0] {
        OP_NOP,   // no memory access
        OP_RD_E,  // read at val_e
        OP_RD_A,  // read at val_a
        OP_WR_A,  // write val_a at val_e
        OP_WR_P   // write val_p at val_e
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dmem_state_e;

    function automatic mem_op_e decode_op(input logic [3:0] icode);
        mem_op_e op;
        case (icode)
            ICODE_MRMOVQ:            op = OP_RD_E;
            ICODE_RET, ICODE_POPQ:   op = OP_RD_A;
            ICODE_RMMOVQ, ICODE_PUSHQ: op = OP_WR_A;
            ICODE_CALL:              op = OP_WR_P;
            default:                 op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data memory: synchronous write, registered read, preloaded with mem[i] = i.
module dmem_array #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned INIT_COUNT = 21,
    parameter int unsigned AW         = 10
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_image();
        mem_t img;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            img[i] = (i < INIT_COUNT) ? DATA_W'(i) : '0;
        end
        return img;
    endfunction

    // Contents are power-up state only; reset never touches the array.
    mem_t mem = init_image();

    logic [DATA_W-1:0] rd_data_q;

    // One access per enable: either store wdata or capture the addressed word.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rd_data_q <= mem[addr];
            end
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/dmem_unit.sv
// Y86 data-memory stage: decodes the icode, sequences a fixed-latency access through
// an IDLE/WAIT/RESP handshake FSM and performs the array access once on entry to RESP.
module dmem_unit
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned INIT_COUNT = 21
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        in_code,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_a,
    input  logic [DATA_W-1:0] val_p,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] val_m,
    output logic              bad_mem,
    output logic [DATA_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_data
);

    localparam int unsigned       AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);
    localparam logic [2:0]        CNT_LOAD = 3'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    mem_op_e           op_q, op_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mem_add_q, mem_add_d;
    logic              bad_mem_q, bad_mem_d;
    logic [DATA_W-1:0] val_m_q, val_m_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              rd_fresh_q, rd_fresh_d;

    logic              is_rd, is_wr;
    logic              arr_en, arr_we;
    logic [DATA_W-1:0] arr_rdata;

    // While a fresh read is being presented, outputs come straight from the array
    // register; the value is folded into val_m_q/mem_data_q when RESP is left.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign val_m      = rd_fresh_q ? arr_rdata : val_m_q;
    assign mem_data   = rd_fresh_q ? arr_rdata : mem_data_q;
    assign bad_mem    = bad_mem_q;
    assign mem_add    = mem_add_q;

    // Next-state, request capture and the one-shot array access on RESP entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        mem_add_d  = mem_add_q;
        bad_mem_d  = bad_mem_q;
        val_m_d    = val_m_q;
        mem_data_d = mem_data_q;
        rd_fresh_d = rd_fresh_q;
        is_rd      = 1'b0;
        is_wr      = 1'b0;
        arr_en     = 1'b0;
        arr_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = decode_op(in_code);
                    case (op_d)
                        OP_RD_E, OP_WR_A, OP_WR_P: mem_add_d = val_e;
                        OP_RD_A:                   mem_add_d = val_a;
                        default:                   mem_add_d = mem_add_q;
                    endcase
                    wdata_d   = (op_d == OP_WR_P) ? val_p : val_a;
                    bad_mem_d = (op_d != OP_NOP) && (mem_add_d >= DEPTH_W);
                    cnt_d     = CNT_LOAD;
                    state_d   = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d    = ST_IDLE;
                    val_m_d    = val_m;
                    mem_data_d = mem_data;
                    rd_fresh_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Access uses the _d view so a LATENCY=1 request is served on its acceptance edge.
        if (state_d == ST_RESP && state_q != ST_RESP && !reset) begin
            is_rd = (op_d == OP_RD_E) || (op_d == OP_RD_A);
            is_wr = (op_d == OP_WR_A) || (op_d == OP_WR_P);
            if (bad_mem_d) begin
                mem_data_d = '0;
                if (is_rd) begin
                    val_m_d = '0;
                end
            end else begin
                arr_en = is_rd || is_wr;
                arr_we = is_wr;
                if (is_rd) begin
                    rd_fresh_d = 1'b1;
                end
                if (is_wr) begin
                    mem_data_d = wdata_d;
                end
            end
        end
    end

    // Control and output registers; the memory array is deliberately outside reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_NOP;
            wdata_q    <= '0;
            mem_add_q  <= '0;
            bad_mem_q  <= 1'b0;
            val_m_q    <= '0;
            mem_data_q <= '0;
            rd_fresh_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            mem_add_q  <= mem_add_d;
            bad_mem_q  <= bad_mem_d;
            val_m_q    <= val_m_d;
            mem_data_q <= mem_data_d;
            rd_fresh_q <= rd_fresh_d;
        end
    end

    dmem_array #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .INIT_COUNT (INIT_COUNT),
        .AW         (AW)
    ) u_array (
        .clock (clock),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (mem_add_d[AW-1:0]),
        .wdata (wdata_d),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: two instances (LATENCY 1 and 3) checked against a word-array model.
module tb_dmem_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [3:0]  in_code;
    logic [63:0] val_e, val_a, val_p;
    logic        resp_valid [2];
    logic        resp_ready;
    logic [63:0] val_m    [2];
    logic        bad_mem  [2];
    logic [63:0] mem_add  [2];
    logic [63:0] mem_data [2];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state per instance
    logic [63:0] mm [2][1024];
    logic [63:0] mv [2];
    logic [63:0] ma [2];
    logic [63:0] md [2];
    logic [3:0]  icodes [8];

    always #5 clock = ~clock;

    dmem_unit #(.DATA_W(64), .DEPTH(1024), .LATENCY(1), .INIT_COUNT(21)) u_dut_l1 (
        .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .in_code(in_code), .val_e(val_e), .val_a(val_a), .val_p(val_p),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .val_m(val_m[0]),
        .bad_mem(bad_mem[0]), .mem_add(mem_add[0]), .mem_data(mem_data[0])
    );

    dmem_unit #(.DATA_W(64), .DEPTH(1024), .LATENCY(3), .INIT_COUNT(21)) u_dut_l3 (
        .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .in_code(in_code), .val_e(val_e), .val_a(val_a), .val_p(val_p),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .val_m(val_m[1]),
        .bad_mem(bad_mem[1]), .mem_add(mem_add[1]), .mem_data(mem_data[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 64'd1024 + 64'($urandom_range(0, 100));
        if (r == 1) return {1'b1, 31'($urandom), 32'($urandom)};
        return 64'($urandom_range(0, 40));
    endfunction

    // One request/response on instance d; optional stall of 'hold' cycles with an
    // injected (ignored) write request while the response is pending.
    task automatic txn(input int d, input logic [3:0] ic, input logic [63:0] e,
                       input logic [63:0] a, input logic [63:0] p,
                       input int hold, input bit inject);
        logic [63:0] addr, wd;
        bit rd, wr, bad, seen;
        int lat;
        rd = 0; wr = 0; addr = '0; wd = '0;
        case (ic)
            4'd5:         begin rd = 1; addr = e; end
            4'd9, 4'd11:  begin rd = 1; addr = a; end
            4'd4, 4'd10:  begin wr = 1; addr = e; wd = a; end
            4'd8:         begin wr = 1; addr = e; wd = p; end
            default: ;
        endcase
        bad = (rd || wr) && (addr >= 64'd1024);
        if (rd || wr) ma[d] = addr;
        if (bad) begin
            md[d] = '0;
            if (rd) mv[d] = '0;
        end else if (wr) begin
            mm[d][addr[9:0]] = wd;
            md[d] = wd;
        end else if (rd) begin
            mv[d] = mm[d][addr[9:0]];
            md[d] = mv[d];
        end

        @(negedge clock);
        chk("req_ready_idle", 64'(req_ready[d]), 64'd1);
        in_code = ic; val_e = e; val_a = a; val_p = p;
        req_valid[d] = 1'b1;
        resp_ready = 1'b0;
        @(posedge clock);
        #1 req_valid[d] = 1'b0;

        seen = 0; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (resp_valid[d]) begin
                seen = 1; lat = k;
                break;
            end
        end
        chk("resp_seen", 64'(seen), 64'd1);
        if (!seen) return;
        chk("latency", 64'(lat), (d == 0) ? 64'd1 : 64'd3);
        chk("bad_mem", 64'(bad_mem[d]), 64'(bad));
        chk("mem_add", mem_add[d], ma[d]);
        if (rd || !wr) chk("val_m", val_m[d], mv[d]);
        if (rd || wr)  chk("mem_data", mem_data[d], md[d]);
        chk("req_ready_busy", 64'(req_ready[d]), 64'd0);

        for (int h = 0; h < hold; h++) begin
            if (inject && h == 0) begin
                in_code = 4'd4; val_e = 64'd7; val_a = 64'hBAD;
                req_valid[d] = 1'b1;
            end
            @(negedge clock);
            chk("hold_resp_valid", 64'(resp_valid[d]), 64'd1);
            chk("hold_req_ready", 64'(req_ready[d]), 64'd0);
            chk("hold_bad_mem", 64'(bad_mem[d]), 64'(bad));
            if (rd) chk("hold_val_m", val_m[d], mv[d]);
            if (rd || wr) chk("hold_mem_data", mem_data[d], md[d]);
        end
        req_valid[d] = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
        chk("released_resp_valid", 64'(resp_valid[d]), 64'd0);
        chk("released_req_ready", 64'(req_ready[d]), 64'd1);
        if (rd || !wr) chk("val_m_after", val_m[d], mv[d]);
    endtask

    task automatic check_cleared(input int d);
        chk("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
        chk("rst_req_ready", 64'(req_ready[d]), 64'd1);
        chk("rst_val_m", val_m[d], 64'd0);
        chk("rst_mem_add", mem_add[d], 64'd0);
        chk("rst_mem_data", mem_data[d], 64'd0);
        chk("rst_bad_mem", 64'(bad_mem[d]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ic;
        logic [63:0] e, a, p;
        int d;

        for (int i = 0; i < 1024; i++) begin
            mm[0][i] = (i < 21) ? 64'(i) : 64'd0;
            mm[1][i] = (i < 21) ? 64'(i) : 64'd0;
        end
        for (int i = 0; i < 2; i++) begin
            mv[i] = '0; ma[i] = '0; md[i] = '0;
        end
        icodes[0] = 4'd4;  icodes[1] = 4'd5;  icodes[2] = 4'd8;  icodes[3] = 4'd9;
        icodes[4] = 4'd10; icodes[5] = 4'd11; icodes[6] = 4'd0;  icodes[7] = 4'd1;

        reset = 1'b1;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        resp_ready = 1'b0;
        in_code = '0; val_e = '0; val_a = '0; val_p = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_cleared(0);
        check_cleared(1);
        reset = 1'b0;

        // mrmovq at LATENCY 1
        txn(0, 4'd5, 64'd7, 64'd0, 64'd0, 0, 0);
        // rmmovq then popq at LATENCY 3
        txn(1, 4'd4, 64'd30, 64'hABCD, 64'd0, 0, 0);
        txn(1, 4'd11, 64'd0, 64'd30, 64'd0, 0, 0);
        // call then ret
        txn(1, 4'd8, 64'd12, 64'd0, 64'h40, 0, 0);
        txn(1, 4'd9, 64'd0, 64'd12, 64'd0, 0, 0);
        // out-of-range read, out-of-range write that would alias index 0 if truncated
        txn(1, 4'd5, 64'd1024, 64'd0, 64'd0, 0, 0);
        txn(1, 4'd4, 64'h100_0000_0000, 64'h55, 64'd0, 0, 0);
        txn(1, 4'd5, 64'd0, 64'd0, 64'd0, 0, 0);
        txn(0, 4'd4, 64'd1024, 64'h66, 64'd0, 1, 0);
        // stalled response with an ignored request, then confirm no write happened
        txn(1, 4'd5, 64'd7, 64'd0, 64'd0, 5, 1);
        txn(1, 4'd5, 64'd7, 64'd0, 64'd0, 0, 0);
        txn(0, 4'd5, 64'd7, 64'd0, 64'd0, 5, 1);
        txn(0, 4'd5, 64'd7, 64'd0, 64'd0, 0, 0);

        // reset while a pushq is waiting
        @(negedge clock);
        in_code = 4'd10; val_e = 64'd3; val_a = 64'hDEAD;
        req_valid[1] = 1'b1;
        @(posedge clock);
        #1 req_valid[1] = 1'b0;
        @(negedge clock);
        chk("wait_resp_valid", 64'(resp_valid[1]), 64'd0);
        reset = 1'b1;
        #1;
        check_cleared(1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mv[i] = '0; ma[i] = '0; md[i] = '0;
        end
        check_cleared(1);
        txn(1, 4'd5, 64'd3, 64'd0, 64'd0, 0, 0);

        // randomized traffic on both instances
        for (int n = 0; n < 40; n++) begin
            d  = int'($urandom_range(0, 1));
            ic = icodes[$urandom_range(0, 7)];
            e  = rand_addr();
            a  = (ic == 4'd9 || ic == 4'd11) ? rand_addr() : {$urandom, $urandom};
            p  = {$urandom, $urandom};
            txn(d, ic, e, a, p, int'($urandom_range(0, 3)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
